param_reg_file: RTL and testbench
=================================

# param_reg_file

Parametrised multi-read-port register file with an integrated busy scoreboard, succeeding the fixed 32×32 two-port register file in the core's decode/writeback path. It adds configurable depth, width and read-port count, an optional hardwired zero register, and optional same-cycle write-to-read bypass. It also tracks per-register "pending write" state, so decode can detect RAW hazards without a separate scoreboard block.

## Interface
- `REG_WIDTH`, 32: data width of every register.
- `NUM_REGS`, 32: number of architectural registers; need not be a power of two, minimum 2.
- `NUM_RD`, 2: number of read ports, 1..4.
- `ZERO_REG`, 1: when 1, register 0 reads as 0, ignores writes and is never busy.
- `BYPASS`, 1: when 1, same-cycle write data forwards to matching read ports.
- `ADDR_W`, derived as clog2(NUM_REGS), minimum 1. Local, not overridable.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `rdAddr` input NUM_RD*ADDR_W: packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- `rdData` output NUM_RD*REG_WIDTH: packed read data, combinational.
- `rdBusy` output NUM_RD: per-port flag meaning the addressed register has a pending write.
- `wrEna` input 1: write strobe.
- `wrAddr` input ADDR_W: write address.
- `wrData` input REG_WIDTH: write data.
- `rsvEna` input 1: reserve strobe; marks a register as the destination of an issued instruction.
- `rsvAddr` input ADDR_W: reserve address.
- `busyCount` output clog2(NUM_REGS+1): number of registers currently busy.

## Operation
- Storage: NUM_REGS×REG_WIDTH flops. Write occurs at the edge when `wrEna` is high and `wrAddr` is valid.
- Invalid address: an address is invalid if it is ≥ NUM_REGS, or if it is 0 with ZERO_REG=1.
  - Writes and reserves to an invalid address are ignored.
  - Reads of an address ≥ NUM_REGS return 0 with `rdBusy` low.
- Read, per port i:
  - If `rst` is high, `rdData` is 0.
  - Otherwise, if BYPASS=1, `wrEna` is high and `wrAddr`==rdAddr_i is a valid address, `rdData` is `wrData`.
  - Otherwise `rdData` is the stored value.
  - Each read port is independent; all ports may select the same register.
- Scoreboard: one busy bit per register.
  - Effective set: `rsvEna` high with a valid `rsvAddr`.
  - Effective clear: `wrEna` high with a valid `wrAddr`.
  - Set and clear on the same address in the same cycle: set wins, because a new producer has been issued. The data write still happens.
  - Set of an already-busy register: stays busy. Clear of an idle register: no effect.
- `rdBusy[i]` = busy[rdAddr_i].
  - With BYPASS=1, it is masked low when an effective clear targets the same address in that cycle, since the data is forwarded.
  - A same-cycle reserve never raises `rdBusy`; it takes effect next cycle.
- `busyCount` is a registered counter, updated each edge by (#bits newly set) − (#bits newly cleared), which is −1, 0 or +1.
  - It never wraps; the bench checks it always equals the popcount of the busy bits.

## Timing
- Reset: at an edge with `rst` high, all registers go to 0, all busy bits go to 0, and `busyCount` goes to 0. `rdData` and `rdBusy` are 0 while `rst` is high.
- `rst` high mid-operation discards all pending reservations and writes in that cycle.
- Write latency:
  - Visible on `rdData` the next cycle.
  - With BYPASS=1, also visible in the same cycle.
- Reserve latency: `rdBusy` and `busyCount` reflect the reserve one cycle after `rsvEna`.
- Clear latency:
  - `busyCount` decrements one cycle after the write.
  - `rdBusy` drops in the same cycle with BYPASS=1, or one cycle later with BYPASS=0.
- Read path is purely combinational; there are no combinational paths from `rsvEna`/`rsvAddr` to any output.

## Structure
- Shared package `regfile_pkg`:
  - clog2 helper function.
  - Address-valid function (addr, NUM_REGS, ZERO_REG).
  - Read-port slice index macros.
- Sub-module `regfile_scoreboard`: busy-bit vector, set/clear priority logic, `busyCount` counter.
  - Parameters NUM_REGS and ZERO_REG.
  - Takes effective set/clear strobes and addresses; outputs the busy vector and count.
- Storage and read muxes live in `param_reg_file` and use generate loops over NUM_REGS and NUM_RD.
- Register 0 is generated as constant 0 when ZERO_REG=1.

## Test plan
- Reset, then write 0xDEADBEEF to r5, read r5 on both ports -> read returns 0xDEADBEEF in the next cycle with BYPASS=1 and BYPASS=0. In the same cycle, the read returns 0xDEADBEEF only when BYPASS=1; with BYPASS=0 it returns 0.
- ZERO_REG=1, write 0x1234 to r0 and reserve r0 -> r0 reads 0, `rdBusy`=0, `busyCount`=0.
- Reserve r3, then r7 on consecutive cycles -> `busyCount` goes 1 then 2. Write r3 -> `rdBusy` for r3 drops (same cycle with BYPASS=1), and `busyCount`=1 next cycle.
- Reserve r9 and write r9 with 0xAA in the same cycle while r9 is busy -> r9=0xAA, r9 stays busy, `busyCount` unchanged.
- NUM_REGS=24, write 0xFF to address 30 and reserve address 30 -> all registers unchanged, read of address 30 returns 0, `busyCount` unchanged.
- Reserve r1..r4 and write r2=0x55, then assert `rst` for one cycle -> all reads return 0, `busyCount`=0, and all `rdBusy` are 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared helpers for the parametrised register file: sizing, address
// validity and packed-port slicing.
`define RF_SLICE(idx, w) ((idx) * (w)) +: (w)

package regfile_pkg;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result++;
      v = v >> 1;
    end
    return result;
  endfunction

  // Out-of-range addresses and the hardwired zero register take no writes or reserves.
  function automatic logic addr_valid(input logic [31:0] addr, input int num_regs,
                                      input int zero_reg);
    return (addr < 32'(num_regs)) && !((zero_reg != 0) && (addr == 32'd0));
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending-write flag per register plus a running
// count of busy registers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 1,
  localparam int ADDR_W = (clog2(NUM_REGS) < 1) ? 1 : clog2(NUM_REGS),
  localparam int CNT_W = clog2(NUM_REGS + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_ena,
  input  logic [ADDR_W-1:0]   set_addr,
  input  logic                clr_ena,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic [NUM_REGS-1:0] busy,
  output logic [CNT_W-1:0]    busy_count
);

  logic [NUM_REGS-1:0] busy_next;
  logic                inc;
  logic                dec;

  // Set is applied after clear so a newly issued producer keeps the register busy.
  always_comb begin
    busy_next = busy;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (clr_ena && clr_addr == ADDR_W'(r)) busy_next[r] = 1'b0;
      if (set_ena && set_addr == ADDR_W'(r)) busy_next[r] = 1'b1;
    end
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
    inc = |(busy_next & ~busy);
    dec = |(busy & ~busy_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_next;
      busy_count <= busy_count + CNT_W'(inc) - CNT_W'(dec);
    end
  end

endmodule

// File: rtl/param_reg_file.sv
// Parametrised multi-read-port register file with optional zero register,
// write-to-read bypass and an integrated busy scoreboard.
module param_reg_file
  import regfile_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS = 1,
  localparam int ADDR_W = (clog2(NUM_REGS) < 1) ? 1 : clog2(NUM_REGS),
  localparam int CNT_W = clog2(NUM_REGS + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_RD*ADDR_W-1:0]    rdAddr,
  output logic [NUM_RD*REG_WIDTH-1:0] rdData,
  output logic [NUM_RD-1:0]           rdBusy,
  input  logic                        wrEna,
  input  logic [ADDR_W-1:0]           wrAddr,
  input  logic [REG_WIDTH-1:0]        wrData,
  input  logic                        rsvEna,
  input  logic [ADDR_W-1:0]           rsvAddr,
  output logic [CNT_W-1:0]            busyCount
);

  logic                          wr_eff;
  logic                          rsv_eff;
  logic [NUM_REGS-1:0]           busy;
  logic [NUM_REGS*REG_WIDTH-1:0] reg_flat;

  assign wr_eff  = wrEna && addr_valid(32'(wrAddr), NUM_REGS, ZERO_REG);
  assign rsv_eff = rsvEna && addr_valid(32'(rsvAddr), NUM_REGS, ZERO_REG);

  regfile_scoreboard #(
    .NUM_REGS(NUM_REGS),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .set_ena   (rsv_eff),
    .set_addr  (rsvAddr),
    .clr_ena   (wr_eff),
    .clr_addr  (wrAddr),
    .busy      (busy),
    .busy_count(busyCount)
  );

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (ZERO_REG != 0 && r == 0) begin : g_zero
      assign reg_flat[`RF_SLICE(r, REG_WIDTH)] = '0;
    end else begin : g_store
      logic [REG_WIDTH-1:0] q;
      always_ff @(posedge clk) begin
        if (rst) q <= '0;
        else if (wr_eff && wrAddr == ADDR_W'(r)) q <= wrData;
      end
      assign reg_flat[`RF_SLICE(r, REG_WIDTH)] = q;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0]    addr;
    logic [REG_WIDTH-1:0] data;
    logic                 busy_bit;

    assign addr = rdAddr[`RF_SLICE(p, ADDR_W)];

    // Forwarded write data also hides the busy flag, since the value is already here.
    always_comb begin
      data     = '0;
      busy_bit = 1'b0;
      for (int r = 0; r < NUM_REGS; r++) begin
        if (addr == ADDR_W'(r)) begin
          data     = reg_flat[r*REG_WIDTH +: REG_WIDTH];
          busy_bit = busy[r];
        end
      end
      if (BYPASS != 0 && wr_eff && wrAddr == addr) begin
        data     = wrData;
        busy_bit = 1'b0;
      end
      if (rst) begin
        data     = '0;
        busy_bit = 1'b0;
      end
    end

    assign rdData[`RF_SLICE(p, REG_WIDTH)] = data;
    assign rdBusy[p] = busy_bit;
  end

endmodule

// File: tb/tb_param_reg_file.sv
// Scoreboard bench for param_reg_file: two configurations share one stimulus
// stream and are checked every cycle against an array-based reference model.
module tb_param_reg_file;

  typedef struct packed {
    logic [63:0] a_data;
    logic [1:0]  a_busy;
    logic [5:0]  a_cnt;
    logic [95:0] b_data;
    logic [2:0]  b_busy;
    logic [4:0]  b_cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [14:0] rd_addr;
  logic        wr_ena;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_ena;
  logic [4:0]  rsv_addr;

  logic [63:0] a_data;
  logic [1:0]  a_busy;
  logic [5:0]  a_cnt;
  logic [95:0] b_data;
  logic [2:0]  b_busy;
  logic [4:0]  b_cnt;

  int tests_run = 0;
  int tests_failed = 0;

  exp_t exp_q[$];

  // Configuration of the two instances: A = 32 regs, zero reg, bypass, 2 ports;
  // B = 24 regs, no zero reg, no bypass, 3 ports.
  int unsigned cfg_nregs[2] = '{32, 24};
  bit          cfg_zero[2] = '{1'b1, 1'b0};
  bit          cfg_bypass[2] = '{1'b1, 1'b0};
  int          cfg_nrd[2] = '{2, 3};

  logic [31:0] m_regs[2][32];
  bit          m_busy[2][32];

  always #5 clk = ~clk;

  param_reg_file #(
    .REG_WIDTH(32), .NUM_REGS(32), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)
  ) dut_a (
    .clk(clk), .rst(rst), .rdAddr(rd_addr[9:0]), .rdData(a_data), .rdBusy(a_busy),
    .wrEna(wr_ena), .wrAddr(wr_addr), .wrData(wr_data),
    .rsvEna(rsv_ena), .rsvAddr(rsv_addr), .busyCount(a_cnt)
  );

  param_reg_file #(
    .REG_WIDTH(32), .NUM_REGS(24), .NUM_RD(3), .ZERO_REG(0), .BYPASS(0)
  ) dut_b (
    .clk(clk), .rst(rst), .rdAddr(rd_addr), .rdData(b_data), .rdBusy(b_busy),
    .wrEna(wr_ena), .wrAddr(wr_addr), .wrData(wr_data),
    .rsvEna(rsv_ena), .rsvAddr(rsv_addr), .busyCount(b_cnt)
  );

  function automatic bit m_valid(int d, logic [4:0] a);
    return (32'(a) < cfg_nregs[d]) && !(cfg_zero[d] && a == 5'd0);
  endfunction

  function automatic logic [31:0] m_read_data(int d, logic [4:0] a);
    if (rst) return 32'd0;
    if (cfg_bypass[d] && wr_ena && wr_addr == a && m_valid(d, wr_addr)) return wr_data;
    if (32'(a) < cfg_nregs[d]) return m_regs[d][a];
    return 32'd0;
  endfunction

  function automatic logic m_read_busy(int d, logic [4:0] a);
    if (rst) return 1'b0;
    if (cfg_bypass[d] && wr_ena && wr_addr == a && m_valid(d, wr_addr)) return 1'b0;
    if (32'(a) < cfg_nregs[d]) return m_busy[d][a];
    return 1'b0;
  endfunction

  function automatic int m_popcount(int d);
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_busy[d][r]);
    return n;
  endfunction

  function automatic exp_t build_expect();
    exp_t e;
    logic [4:0] a;
    e = '0;
    for (int p = 0; p < cfg_nrd[0]; p++) begin
      a = rd_addr[p*5 +: 5];
      e.a_data[p*32 +: 32] = m_read_data(0, a);
      e.a_busy[p] = m_read_busy(0, a);
    end
    for (int p = 0; p < cfg_nrd[1]; p++) begin
      a = rd_addr[p*5 +: 5];
      e.b_data[p*32 +: 32] = m_read_data(1, a);
      e.b_busy[p] = m_read_busy(1, a);
    end
    e.a_cnt = 6'(m_popcount(0));
    e.b_cnt = 5'(m_popcount(1));
    return e;
  endfunction

  // The write lands first, then the reserve, so a same-cycle reserve leaves the register busy.
  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          m_regs[d][r] = 32'd0;
          m_busy[d][r] = 1'b0;
        end
      end else begin
        if (wr_ena && m_valid(d, wr_addr)) begin
          m_regs[d][wr_addr] = wr_data;
          m_busy[d][wr_addr] = 1'b0;
        end
        if (rsv_ena && m_valid(d, rsv_addr)) m_busy[d][rsv_addr] = 1'b1;
      end
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [14:0] ra, input logic we,
                               input logic [4:0] wa, input logic [31:0] wd,
                               input logic re, input logic [4:0] rsa);
    rst      = r;
    rd_addr  = ra;
    wr_ena   = we;
    wr_addr  = wa;
    wr_data  = wd;
    rsv_ena  = re;
    rsv_addr = rsa;
    exp_q.push_back(build_expect());
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [95:0] actual,
                             input logic [95:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("A.rdData", 96'(a_data), 96'(e.a_data));
      checkOutput("A.rdBusy", 96'(a_busy), 96'(e.a_busy));
      checkOutput("A.busyCount", 96'(a_cnt), 96'(e.a_cnt));
      checkOutput("B.rdData", b_data, e.b_data);
      checkOutput("B.rdBusy", 96'(b_busy), 96'(e.b_busy));
      checkOutput("B.busyCount", 96'(b_cnt), 96'(e.b_cnt));
    end
  end

  function automatic logic [14:0] all3(logic [4:0] a);
    return {a, a, a};
  endfunction

  function automatic logic [4:0] pick_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    rst = 1'b1;
    rd_addr = '0;
    wr_ena = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rsv_ena = 1'b0;
    rsv_addr = '0;
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < 32; r++) begin
        m_regs[d][r] = 32'd0;
        m_busy[d][r] = 1'b0;
      end
    @(posedge clk);
    #1;

    // Directed scenarios: bypass visibility, zero register, reserve/clear, set-wins,
    // out-of-range address, reset mid-operation.
    applyStimulus(0, all3(5'd5), 1, 5'd5, 32'hDEADBEEF, 0, 5'd0);
    applyStimulus(0, all3(5'd5), 0, 5'd0, 32'd0, 0, 5'd0);
    applyStimulus(0, all3(5'd0), 1, 5'd0, 32'h1234, 1, 5'd0);
    applyStimulus(0, all3(5'd0), 0, 5'd0, 32'd0, 0, 5'd0);
    applyStimulus(0, {5'd3, 5'd7, 5'd3}, 0, 5'd0, 32'd0, 1, 5'd3);
    applyStimulus(0, {5'd3, 5'd7, 5'd3}, 0, 5'd0, 32'd0, 1, 5'd7);
    applyStimulus(0, {5'd3, 5'd7, 5'd3}, 1, 5'd3, 32'h33, 0, 5'd0);
    applyStimulus(0, {5'd3, 5'd7, 5'd3}, 0, 5'd0, 32'd0, 0, 5'd0);
    applyStimulus(0, all3(5'd9), 0, 5'd0, 32'd0, 1, 5'd9);
    applyStimulus(0, all3(5'd9), 1, 5'd9, 32'hAA, 1, 5'd9);
    applyStimulus(0, all3(5'd9), 0, 5'd0, 32'd0, 0, 5'd0);
    applyStimulus(0, all3(5'd30), 1, 5'd30, 32'hFF, 1, 5'd30);
    applyStimulus(0, {5'd30, 5'd31, 5'd30}, 0, 5'd0, 32'd0, 0, 5'd0);
    for (int i = 1; i <= 4; i++)
      applyStimulus(0, {5'd1, 5'd2, 5'(i)}, (i == 4), 5'd2, 32'h55, 1, 5'(i));
    applyStimulus(0, {5'd3, 5'd2, 5'd1}, 0, 5'd0, 32'd0, 0, 5'd0);
    applyStimulus(1, {5'd3, 5'd2, 5'd1}, 1, 5'd4, 32'h77, 1, 5'd6);
    applyStimulus(0, {5'd3, 5'd2, 5'd1}, 0, 5'd0, 32'd0, 0, 5'd0);
    applyStimulus(0, {5'd6, 5'd5, 5'd4}, 0, 5'd0, 32'd0, 0, 5'd0);

    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 63) == 0),
                    {pick_addr(), pick_addr(), pick_addr()},
                    ($urandom_range(0, 1) == 1), pick_addr(), $urandom(),
                    ($urandom_range(0, 4) < 2), pick_addr());
    end

    @(negedge clk);
    @(negedge clk);
    checkOutput("queue_drained", 96'(exp_q.size()), 96'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
